dpram_port_arbiter: RTL and testbench
=====================================

// Module: dpram_port_arbiter
// PURPOSE
//  Shares one port of a dpram instance (address/data/wren/byteena/q) between NREQ requesters.
//  - Round-robin arbitration with a per-request req/ack handshake.
//  - Read data is returned tagged with the requester id.
//  - Sits between the PPU/APU/CPU-side bus agents and a single RAM port.
//  - The other RAM port stays free for a dedicated agent.
// PARAMETERS
//  NREQ   3   number of requesters (2..8)
//  AW     11  RAM address width (matches RAM widthad_a)
//  DW     8   RAM data width, multiple of 8 (matches RAM width_a)
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  reset        in   1          asynchronous, active-high reset
//  req          in   NREQ       per-requester request, held high until ack
//  we           in   NREQ       per-requester write (1) / read (0)
//  addr         in   NREQ*AW    flattened addresses, requester i at [i*AW +: AW]
//  wdata        in   NREQ*DW    flattened write data
//  be           in   NREQ*DW/8  flattened byte enables (writes only)
//  ack          out  NREQ       one-cycle pulse: request accepted and issued to RAM
//  rvalid       out  1          read data valid
//  rid          out  IDW        requester id of rdata, IDW = max(1,$clog2(NREQ))
//  rdata        out  DW         read data
//  mem_address  out  AW         to RAM address port
//  mem_data     out  DW         to RAM data port
//  mem_wren     out  1          to RAM wren
//  mem_byteena  out  DW/8       to RAM byteena
//  mem_q        in   DW         from RAM q (registered in RAM, 1-cycle read latency)
// BEHAVIOUR
//  Reset values
//  - ack=0, rvalid=0, rid=0, rdata=0 (when RDBUF is compiled in).
//  - mem_wren=0, mem_address=0, mem_data=0, mem_byteena=0.
//  - RR pointer=0, so requester 0 has first priority.
//  Arbitration
//  - Cycle T: eligible = req & ~ack.
//  - A requester acked in T cannot win in T. This prevents double-issue of a still-held req.
//  - Winner = first eligible in order ptr, ptr+1 .. ptr+NREQ-1 (mod NREQ).
//  - On a grant to winner i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
//  Issue
//  - On edge T+1, mem_* are registered from winner i and ack[i]=1 during T+1.
//  - mem_wren = we[i]. mem_byteena = be[i] on writes, all-ones on reads.
//  - With no grant: mem_wren=0; address/data/byteena hold their previous values (harmless read).
//  Throughput
//  - Aggregate: 1 access/cycle.
//  - A single requester: 1 access per 2 cycles.
//  - The requester drops req or presents its next access on the cycle after ack.
//  Read return
//  - The RAM samples the address at edge T+2; mem_q is valid during T+2.
//  - rvalid=1 and rid=i during T+2 (no RDBUF).
//  - rdata = mem_q passthrough.
//  - Writes produce no rvalid. The RAM does not update q on a write cycle.
//  Simultaneous events
//  - Any number of reqs: exactly one ack per cycle, at most.
//  - Ptr wrap: NREQ-1 -> 0.
//  Reset mid-operation
//  - Async reset clears ack/rvalid/mem_wren immediately.
//  - An issued-but-not-yet-sampled write may be dropped; the requester reissues after reset.
//  - Pending rvalid is discarded.
//  Protocol
//  - we/addr/wdata/be stable while req=1 and until ack.
//  - Changing them before ack is undefined.
// CONFIGURATION
//  DPRAM_ARB_RDBUF_EN defined
//  - rdata/rid/rvalid are registered from mem_q and the issue tag.
//  - Read latency becomes ack+2: rvalid in T+3.
//  - Breaks the RAM-to-consumer timing path.
//  DPRAM_ARB_RDBUF_EN undefined
//  - rvalid/rid are registered; rdata = mem_q combinationally.
//  - rvalid in T+2.
// STRUCTURE
//  Package dpram_arb_pkg
//  - localparam IDW function (clog2 with min 1).
//  - Typedef of the issue tag {valid, is_read, id}.
//  - RDBUF latency constant (1 or 2) used by the testbench.
//  Sub-module dpram_rr_pick (combinational)
//  - in: eligible[NREQ], ptr.
//  - out: grant_valid, grant_id.
//  - Implemented with a double-width rotate and priority encode.
//  Top level
//  - Holds the ptr, issue registers, ack register and return-tag pipeline.
// TESTING
//  Bench instantiates the arbiter with a real dpram (AW=4, DW=16) and runs each directed test with RDBUF on and off.
//  1. Reset.
//     - Assert reset mid-run -> all outputs 0 within the same cycle.
//     - First grant after release goes to req0 when all three reqs are high.
//  2. Fairness.
//     - req=3'b111 held continuously, each requester re-requesting after its ack.
//     - -> ack order 0,1,2,0,1,2, one per cycle, no gaps.
//  3. Write then read.
//     - req1 writes 0xBEEF to addr 5 with be=2'b11; req1 then reads addr 5.
//     - -> rvalid with rid=1, rdata=0xBEEF at ack+1 (ack+2 with RDBUF).
//  4. Byte enable.
//     - Write 0x1234 to addr 3, then write 0xAB00 with be=2'b10, then read.
//     - -> rdata=0xAB34; no rvalid on either write.
//  5. Single requester, req held high.
//     - -> ack pulses on alternate cycles only; mem_wren is never high two consecutive cycles for the same access.
//  6. Wrap/skip.
//     - ptr=2 with only req0 high.
//     - -> req0 is granted and ptr becomes 1; no grant to idle requesters.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared types and constants for the dpram port arbiter.
// DPRAM_ARB_RDBUF_EN selects the registered read-return path (affects RD_LAT).
package dpram_arb_pkg;

    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic               is_read;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    // Cycles from ack to rvalid
`ifdef DPRAM_ARB_RDBUF_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/dpram_rr_pick.sv
// dpram_rr_pick: combinational round-robin picker, first eligible at or after ptr.
module dpram_rr_pick #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  ptr,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id
);

    logic [NREQ-1:0] rot;

    assign rot = NREQ'({eligible, eligible} >> ptr);

    // Scan downward so the lowest rotated position (closest to ptr) wins
    always_comb begin
        grant_valid = |rot;
        grant_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k])
                grant_id = IDW'((int'(ptr) + k >= NREQ) ? int'(ptr) + k - NREQ : int'(ptr) + k);
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one dpram port among NREQ requesters.
// Define DPRAM_ARB_RDBUF_EN to register rdata/rid/rvalid (one extra cycle of read latency).
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 11,
    parameter int DW   = 8,
    localparam int IDW = idw(NREQ),
    localparam int BW  = DW / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [NREQ*BW-1:0] be,
    output logic [NREQ-1:0]   ack,
    output logic              rvalid,
    output logic [IDW-1:0]    rid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     mem_address,
    output logic [DW-1:0]     mem_data,
    output logic              mem_wren,
    output logic [BW-1:0]     mem_byteena,
    input  logic [DW-1:0]     mem_q
);

    logic [NREQ-1:0] eligible, ack_q, ack_d;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id, ptr_q, ptr_d, rid_q, rid_d;
    logic            mem_wren_q, mem_wren_d, rvalid_q, rvalid_d;
    logic [AW-1:0]   mem_address_q, mem_address_d;
    logic [DW-1:0]   mem_data_q, mem_data_d;
    logic [BW-1:0]   mem_byteena_q, mem_byteena_d;
    tag_t            tag_q, tag_d;
`ifdef DPRAM_ARB_RDBUF_EN
    tag_t            ret_q, ret_d;
    logic [DW-1:0]   rdata_q, rdata_d;
`endif

    // A requester being acked this cycle still holds req; mask it out
    assign eligible = req & ~ack_q;

    dpram_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .eligible    (eligible),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        ptr_d         = !grant_valid ? ptr_q : (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        ack_d         = grant_valid ? NREQ'(1) << grant_id : '0;
        mem_wren_d    = grant_valid & we[grant_id];
        mem_address_d = grant_valid ? addr[int'(grant_id)*AW +: AW] : mem_address_q;
        mem_data_d    = grant_valid ? wdata[int'(grant_id)*DW +: DW] : mem_data_q;
        mem_byteena_d = !grant_valid ? mem_byteena_q : we[grant_id] ? be[int'(grant_id)*BW +: BW] : '1;
        tag_d         = {grant_valid, ~we[grant_id], TAG_IDW'(grant_id)};
`ifdef DPRAM_ARB_RDBUF_EN
        ret_d         = tag_q;
        rvalid_d      = ret_q.valid & ret_q.is_read;
        rid_d         = IDW'(ret_q.id);
        rdata_d       = (ret_q.valid & ret_q.is_read) ? mem_q : rdata_q;
`else
        rvalid_d      = tag_q.valid & tag_q.is_read;
        rid_d         = IDW'(tag_q.id);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            ack_q         <= '0;
            mem_wren_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_byteena_q <= '0;
            tag_q         <= '0;
            rvalid_q      <= 1'b0;
            rid_q         <= '0;
`ifdef DPRAM_ARB_RDBUF_EN
            ret_q         <= '0;
            rdata_q       <= '0;
`endif
        end else begin
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            mem_wren_q    <= mem_wren_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_byteena_q <= mem_byteena_d;
            tag_q         <= tag_d;
            rvalid_q      <= rvalid_d;
            rid_q         <= rid_d;
`ifdef DPRAM_ARB_RDBUF_EN
            ret_q         <= ret_d;
            rdata_q       <= rdata_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign rvalid      = rvalid_q;
    assign rid         = rid_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign mem_byteena = mem_byteena_q;
`ifdef DPRAM_ARB_RDBUF_EN
    assign rdata       = rdata_q;
`else
    assign rdata       = mem_q;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed scoreboard bench with a behavioural 16x16 dpram port.
module tb_dpram_port_arbiter;
    import dpram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0, we = '0;
    logic [11:0] addr = '0;
    logic [47:0] wdata = '0;
    logic [5:0]  be = '0;
    logic [2:0]  ack;
    logic        rvalid, mem_wren;
    logic [1:0]  rid, mem_byteena;
    logic [15:0] rdata, mem_data, mem_q;
    logic [3:0]  mem_address;
    logic [15:0] ram [16];

    typedef struct { logic w; logic [3:0] a; logic [15:0] d; logic [1:0] b; } op_t;
    typedef struct { int id; int cyc; } ackx_t;
    typedef struct { int id; logic [15:0] d; int cyc; } rdx_t;

    op_t   opq [3][$];
    ackx_t ackq[$];
    rdx_t  rdq[$];
    int    cyc = 0, tests = 0, fails = 0, n;
    logic  chk_wren = 1'b0, prev_wren = 1'b0;

    dpram_port_arbiter #(.NREQ(3), .AW(4), .DW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_byteena(mem_byteena), .mem_q(mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM port: registered q, q untouched on write cycles
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 2; b++)
                if (mem_byteena[b]) ram[mem_address][b*8 +: 8] <= mem_data[b*8 +: 8];
        end else begin
            mem_q <= ram[mem_address];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 3; i++) begin
            req[i] = opq[i].size() > 0;
            if (req[i]) begin
                we[i]              = opq[i][0].w;
                addr[i*4 +: 4]     = opq[i][0].a;
                wdata[i*16 +: 16]  = opq[i][0].d;
                be[i*2 +: 2]       = opq[i][0].b;
            end
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                if (req[i] && ack[i]) opq[i].delete(0);
            apply();
        end
    endtask

    task automatic wr(input int i, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        opq[i].push_back('{1'b1, a, d, b});
    endtask

    task automatic rd(input int i, input logic [3:0] a);
        opq[i].push_back('{1'b0, a, 16'h0, 2'b11});
    endtask

    task automatic exp_ack(input int id, input int c);
        ackq.push_back('{id, c});
    endtask

    task automatic exp_rd(input int id, input logic [15:0] d, input int c);
        rdq.push_back('{id, d, c});
    endtask

    function automatic bit busy();
        return ackq.size() > 0 || rdq.size() > 0 || opq[0].size() > 0 || opq[1].size() > 0 || opq[2].size() > 0;
    endfunction

    task automatic drain(input string name);
        int k = 0;
        while (busy() && k < 40) begin
            step(1);
            k++;
        end
        step(3);
        check({name, "_drained"}, 64'(ackq.size() + rdq.size()), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"}, ack, 0);
        check({name, "_rvalid"}, rvalid, 0);
        check({name, "_rid"}, rid, 0);
        check({name, "_wren"}, mem_wren, 0);
        check({name, "_mem"}, {mem_address, mem_data, mem_byteena}, 0);
`ifdef DPRAM_ARB_RDBUF_EN
        check({name, "_rdata"}, rdata, 0);
`endif
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
    task automatic do_reset(input string name);
        #1 reset = 1'b1;
        ackq.delete();
        rdq.delete();
        for (int i = 0; i < 3; i++) opq[i].delete();
        req = '0;
        prev_wren = 1'b0;
        #1 check_reset_outputs(name);
        step(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        ackx_t ea;
        rdx_t  er;
        if (!reset) begin
            if (ack != 0) begin
                if (ackq.size() == 0) check("ack_spurious", ack, 0);
                else begin
                    ea = ackq.pop_front();
                    check("ack_id", ack, 3'b001 << ea.id);
                    check("ack_cyc", 64'(cyc), 64'(ea.cyc));
                end
            end
            if (rvalid) begin
                if (rdq.size() == 0) check("rvalid_spurious", rvalid, 0);
                else begin
                    er = rdq.pop_front();
                    check("rid", rid, 64'(er.id));
                    check("rdata", rdata, er.d);
                    check("rvalid_cyc", 64'(cyc), 64'(er.cyc));
                end
            end
            if (chk_wren && mem_wren) check("wren_back_to_back", prev_wren, 0);
            prev_wren = mem_wren;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        step(2);
        check_reset_outputs("por");
        reset = 1'b0;
        step(1);

        // Reset mid-run, then first grant goes to req0
        wr(0, 0, 16'h1111, 2'b11); wr(1, 1, 16'h2222, 2'b11); wr(2, 2, 16'h3333, 2'b11);
        apply(); n = cyc;
        exp_ack(0, n + 1);
        step(2);
        do_reset("midrst");
        wr(0, 0, 16'h1111, 2'b11); wr(1, 1, 16'h2222, 2'b11); wr(2, 2, 16'h3333, 2'b11);
        apply(); n = cyc;
        exp_ack(0, n + 1); exp_ack(1, n + 2); exp_ack(2, n + 3);
        drain("t1");

        // Fairness: 0,1,2,0,1,2 back to back
        do_reset("rst2");
        for (int i = 0; i < 3; i++) begin
            wr(i, 4'(i), 16'h0100 + 16'(i), 2'b11);
            wr(i, 4'(i + 3), 16'h0200 + 16'(i), 2'b11);
        end
        apply(); n = cyc;
        for (int j = 0; j < 6; j++) exp_ack(j % 3, n + 1 + j);
        drain("t2");

        // Write then read on req1
        do_reset("rst3");
        wr(1, 5, 16'hBEEF, 2'b11); rd(1, 5);
        apply(); n = cyc;
        exp_ack(1, n + 1); exp_ack(1, n + 3); exp_rd(1, 16'hBEEF, n + 3 + RD_LAT);
        drain("t3");

        // Byte enable merge
        do_reset("rst4");
        wr(2, 3, 16'h1234, 2'b11); wr(2, 3, 16'hAB00, 2'b10); rd(2, 3);
        apply(); n = cyc;
        exp_ack(2, n + 1); exp_ack(2, n + 3); exp_ack(2, n + 5); exp_rd(2, 16'hAB34, n + 5 + RD_LAT);
        drain("t4");

        // Single requester holding req: ack every other cycle
        do_reset("rst5");
        chk_wren = 1'b1;
        wr(0, 7, 16'h7777, 2'b11); wr(0, 8, 16'h5A5A, 2'b11); wr(0, 9, 16'h9999, 2'b11); rd(0, 8);
        apply(); n = cyc;
        for (int j = 0; j < 4; j++) exp_ack(0, n + 1 + 2 * j);
        exp_rd(0, 16'h5A5A, n + 7 + RD_LAT);
        drain("t5");
        chk_wren = 1'b0;

        // Wrap/skip: ptr=2 with only req0, then ptr=1 favours req1 over req0
        do_reset("rst6");
        wr(1, 10, 16'h0A0A, 2'b11);
        apply(); n = cyc;
        exp_ack(1, n + 1);
        step(2);
        wr(0, 11, 16'h0B0B, 2'b11);
        apply();
        exp_ack(0, n + 3);
        step(2);
        rd(0, 10); rd(1, 10);
        apply();
        exp_ack(1, n + 5); exp_ack(0, n + 6);
        exp_rd(1, 16'h0A0A, n + 5 + RD_LAT); exp_rd(0, 16'h0A0A, n + 6 + RD_LAT);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
